// File: rtl/sec_corrector_24bits_clk.sv
// Single-error corrector front-end for a 24-bit data word carried in a 32-bit
// codeword. The block hands the captured codeword to an external locator and
// waits a bounded time for the answer. It then flips the reported data bit (if
// any) and presents the result with a valid/ready handshake.
module sec_corrector_24bits_clk #(
    parameter int W_BITS  = 32,
    parameter int N_BITS  = 25,
    parameter int D_BITS  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,              // active-high synchronous reset
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] W_in,
    output logic              loc_start,
    output logic [W_BITS-1:0] loc_W,
    input  logic              loc_found,
    input  logic [N_BITS-1:0] loc_N,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [D_BITS-1:0] data_out,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic [15:0]       corr_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOCATE, S_WAIT, S_OUT} state_t;

    state_t            state, state_nx;
    logic [W_BITS-1:0] w_reg;
    logic [N_BITS-1:0] n_reg;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_inc;
    logic              timed_out;
    logic              timer_done;

    logic              no_err;
    logic              in_range;
    logic [4:0]        idx;
    logic              corr_hit;
    logic              unc_hit;

    // The timer counts WAIT cycles. "Reaching" TIMEOUT-1 is judged on the
    // incremented value, so loc_start-to-out_valid is exactly TIMEOUT cycles.
    assign timer_inc  = timer + 1'b1;
    assign timer_done = (timer_inc == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        loc_start = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_LOCATE;
            end
            S_LOCATE: begin
                loc_start = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                // A found result in the final cycle wins over the timeout.
                if (loc_found || timer_done) state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Codeword/location capture, WAIT timer and corrected-word counter
    always_ff @(posedge clk) begin
        if (rst_n) begin
            w_reg     <= '0;
            n_reg     <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
            corr_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) w_reg <= W_in;
                end
                S_LOCATE: begin
                    timer     <= '0;
                    timed_out <= 1'b0;
                end
                S_WAIT: begin
                    if (loc_found) begin
                        n_reg <= loc_N;
                    end else begin
                        timer <= timer_inc;
                        if (timer_done) timed_out <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready && err_corrected && corr_cnt != 16'hFFFF)
                        corr_cnt <= corr_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign loc_W = w_reg;

    // Location decode. n_reg is stale after a timeout, so timed_out masks it.
    always_comb begin
        no_err   = (n_reg == N_BITS'(32'h00FF_FFFF));
        in_range = (n_reg < N_BITS'(32));
        idx      = n_reg[4:0];
        corr_hit = !timed_out && !no_err && in_range;
        unc_hit  = timed_out || (!no_err && !in_range);
        data_out = w_reg[D_BITS-1:0];
        // Indices at or above D_BITS land in the check bits: data unchanged.
        if (corr_hit && (int'(idx) < D_BITS))
            data_out = w_reg[D_BITS-1:0] ^ (D_BITS'(1) << idx);
        err_corrected     = out_valid && corr_hit;
        err_uncorrectable = out_valid && unc_hit;
    end

endmodule

// File: doc/sec_corrector_24bits_clk.md
SEC_CORRECTOR_24BITS_CLK -- requirements
Module: sec_corrector_24bits_clk

Interface
REQ-001 Parameter W_BITS, default 32, width of the received codeword (data in [23:0], check bits in [31:24]).
REQ-002 Parameter N_BITS, default 25, width of the location word returned by the locator.
REQ-003 Parameter D_BITS, default 24, width of corrected data.
REQ-004 Parameter TIMEOUT, default 64, number of WAIT cycles before the locator is abandoned.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous reset, active-high (asserted = 1, sampled on rising clk).
REQ-007 in_valid  input  1  upstream codeword valid.
REQ-008 in_ready  output  1  block can accept a codeword.
REQ-009 W_in  input  W_BITS  received codeword.
REQ-010 loc_start  output  1  one-cycle pulse requesting a location search.
REQ-011 loc_W  output  W_BITS  codeword presented to the locator, held stable from loc_start to capture.
REQ-012 loc_found  input  1  locator result valid.
REQ-013 loc_N  input  N_BITS  locator result.
REQ-014 out_valid  output  1  corrected result valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 data_out  output  D_BITS  corrected data.
REQ-017 err_corrected  output  1  single-bit error was flipped.
REQ-018 err_uncorrectable  output  1  invalid location or timeout.
REQ-019 corr_cnt  output  16  saturating count of corrected words.

Function
REQ-020 FSM states IDLE, LOCATE, WAIT, OUT; reset state IDLE.
REQ-021 IDLE: in_ready=1; in_valid=1 captures W_in into an internal register and moves to LOCATE; otherwise stays in IDLE.
REQ-022 LOCATE: loc_start=1 for exactly this cycle; WAIT timer cleared to 0; next state WAIT.
REQ-023 loc_W SHALL equal the captured codeword in every state; in_ready=0 outside IDLE.
REQ-024 WAIT: loc_found=1 captures loc_N and moves to OUT; otherwise the timer increments.
REQ-025 WAIT: timer reaching TIMEOUT-1 without loc_found moves to OUT flagged as timeout; loc_found in that same cycle takes priority over timeout.
REQ-026 loc_found is ignored in IDLE, LOCATE and OUT.
REQ-027 Decode of captured loc_N: value 25'h0FFFFFF means no error; value 0..31 means a single error at that bit index of W; any other value is uncorrectable.
REQ-028 No error: data_out = W[23:0], err_corrected=0, err_uncorrectable=0.
REQ-029 Index 0..23: data_out = W[23:0] with bit loc_N inverted, err_corrected=1.
REQ-030 Index 24..31: data_out = W[23:0] unchanged (check-bit error), err_corrected=1.
REQ-031 Uncorrectable or timeout: data_out = W[23:0] unchanged, err_corrected=0, err_uncorrectable=1.
REQ-032 OUT: out_valid=1 and data_out/flags held stable until out_ready=1; on that cycle return to IDLE.
REQ-033 out_valid, err_corrected and err_uncorrectable are 0 outside OUT.
REQ-034 corr_cnt increments by 1 on each out_valid&&out_ready cycle with err_corrected=1, saturating at 16'hFFFF.
REQ-035 Latency: W_in accepted in cycle T, loc_start in T+1, loc_found in T+1+k (k>=1) gives out_valid in T+2+k.
REQ-036 Back-to-back: the earliest next acceptance is the cycle after the out_ready handshake (no overlap).

Reset
REQ-037 rst_n=1 at a rising edge forces IDLE, clears the codeword, location, timer and corr_cnt registers to 0; loc_start, out_valid, err_corrected and err_uncorrectable = 0; in_ready = 1 in the first cycle after reset.
REQ-038 Reset asserted mid-transaction (LOCATE, WAIT or OUT) abandons it; no out_valid is produced for that codeword.

Verification
REQ-039 W_in=32'h00ABCDEF, loc_found after 3 cycles with loc_N=25'h0FFFFFF -> data_out=24'hABCDEF, err_corrected=0, out_valid 5 cycles after acceptance.
REQ-040 W_in=32'h00ABCDEF, loc_N=4 -> data_out=24'hABCDFF, err_corrected=1, corr_cnt=1.
REQ-041 loc_N=27 -> data_out unchanged, err_corrected=1; loc_N=40 -> err_uncorrectable=1.
REQ-042 loc_found never asserted -> out_valid with err_uncorrectable=1 exactly TIMEOUT cycles after loc_start.
REQ-043 out_ready held 0 for 10 cycles -> out_valid and data_out stable; in_ready=0 throughout; a new in_valid is not accepted.
REQ-044 rst_n=1 pulsed during WAIT, then a late loc_found -> no out_valid, state IDLE, corr_cnt=0.
